io_access_ctrl: RTL
===================

Name: io_access_ctrl

Overview:
- Multi-cycle sequencer for memory-mapped IO accesses. The control unit flags an access as IO when the high 22 bits of the ALU result are all ones.
- Sits between the control unit's IORead/IOWrite outputs and the peripheral controllers (LED, switch, 7-seg, buzzer).
- Decodes the target device, drives chip-select and strobes, waits for the device's ready, and stalls the PC/IFetch until the access completes.
- Returns read data to the MemorIO write-back mux.
- Enforces a timeout and reports protocol errors.

Parameters:
TIMEOUT, 15, maximum cycles spent in REQ before forced completion (1..255)
ERR_DATA, 16'hDEAD, value returned on io_rdata for a timed-out or unmapped read

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
io_read  in  1  IORead from control unit
io_write  in  1  IOWrite from control unit
addr_low  in  8  ALU result bits [7:0]
wdata  in  16  store data (register rt, low 16 bits)
dev_ready  in  4  per-device ready: bit0 LED, bit1 switch, bit2 7-seg, bit3 buzzer
dev_rdata  in  64  per-device read data; device n uses bits [16n+15:16n]
err_clr  in  1  clears io_err
io_cs  out  4  one-hot device chip-select
io_rd  out  1  read strobe
io_wr  out  1  write strobe
io_wdata  out  16  write data, registered
io_rdata  out  16  read result, registered, held until next read completes
stall  out  1  freezes PC/IFetch; combinational
io_err  out  1  sticky error flag

Behaviour:
- Reset, synchronous, applied at the clock edge: state=IDLE, io_cs=0, io_rd=0, io_wr=0, io_wdata=0, io_rdata=0, io_err=0, counter=0.
  - While reset=1, stall=0 regardless of inputs.
  - Reset asserted in REQ aborts the access; no data latched, no error set.
- Decode by addr_low[7:4]: 6 = LED (dev0), 7 = switch (dev1), 8 = 7-seg (dev2), 9 = buzzer (dev3). Any other value is unmapped.
- req = io_read XOR io_write.
- IDLE:
  - If req and the address is mapped: stall=1 in the same cycle. Latch device index, direction and wdata. Go to REQ.
  - If req and the address is unmapped: stall=0 and the access completes as a no-op.
    - Read: io_rdata<=ERR_DATA.
    - io_err<=1.
    - Stay in IDLE.
  - If io_read and io_write are both 1: no access, stall=0, io_err<=1.
- REQ:
  - Outputs: io_cs one-hot for the latched device; io_rd or io_wr per direction; stall=1.
  - The counter increments each REQ cycle, starting from 1 on the first REQ cycle.
  - dev_ready[latched dev]=1: on a read, io_rdata<=that device's dev_rdata slice. Go to DONE.
  - Otherwise, when counter==TIMEOUT: on a read, io_rdata<=ERR_DATA. io_err<=1. Go to DONE.
  - Ready takes priority over timeout when both occur in the same cycle.
  - Ready from a non-selected device is ignored.
- DONE, exactly one cycle:
  - io_cs=0, io_rd=0, io_wr=0, stall=0.
  - The PC advances at the end of this cycle. Any req seen in DONE is ignored, since it belongs to the still-completing instruction.
  - Next state IDLE; counter<=0.
- Latency: access with ready on the first REQ cycle = 3 cycles (IDLE detect, REQ, DONE), with stall high for 2.
- io_err: set on any error event; cleared by err_clr. If a set and err_clr occur in the same cycle, the set wins.
- io_wdata is loaded only on IDLE->REQ for writes and holds otherwise.
- Counter is 8 bits; it cannot wrap because TIMEOUT<=255.

Test Plan:
- Read switch: io_read=1, addr_low=8'h70, dev_rdata[31:16]=16'h00A5, dev_ready[1] rises on 2nd REQ cycle.
  - Expect io_cs=4'b0010, io_rd=1, and stall high for 3 cycles.
  - Expect io_rdata=16'h00A5 in the DONE cycle and io_err=0.
- Write LED: io_write=1, addr_low=8'h60, wdata=16'h1234, dev_ready[0]=1 immediately.
  - Expect io_wdata=16'h1234 and io_wr=1 with io_cs=4'b0001 for 1 cycle, then DONE.
  - Expect io_rdata unchanged.
- Timeout: read addr 8'h80 with dev_ready=0, TIMEOUT=15.
  - Expect exactly 15 REQ cycles, then io_rdata=16'hDEAD and io_err=1 in DONE.
  - err_clr pulse clears io_err.
- Unmapped and illegal requests:
  - Read addr 8'hC0: stall never asserted, io_rdata=16'hDEAD, io_err=1.
  - io_read=io_write=1: no cs, stall=0, io_err=1.
- Reset mid-access: assert reset on the 3rd REQ cycle of a write.
  - Next cycle: state IDLE, io_cs=0, stall=0, io_err=0, io_wdata=0.
- Back-to-back: two reads to dev1 on consecutive instructions.
  - Requests held high through DONE produce exactly two accesses, separated by the DONE cycle.
  - Ready on dev0 during a dev1 access is ignored.

Source files
------------

// File: rtl/io_access_ctrl.sv
// Multi-cycle sequencer for memory-mapped IO: decodes the target peripheral,
// drives chip-select/strobes, waits for ready or timeout, and stalls the front end.
module io_access_ctrl #(
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [15:0] ERR_DATA = 16'hDEAD
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_read,
  input  logic        io_write,
  input  logic [7:0]  addr_low,
  input  logic [15:0] wdata,
  input  logic [3:0]  dev_ready,
  input  logic [63:0] dev_rdata,
  input  logic        err_clr,
  output logic [3:0]  io_cs,
  output logic        io_rd,
  output logic        io_wr,
  output logic [15:0] io_wdata,
  output logic [15:0] io_rdata,
  output logic        stall,
  output logic        io_err
);

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns {mapped, device index} for the address nibble.
  function automatic logic [2:0] decode_dev(input logic [3:0] nib);
    case (nib)
      4'h6:    decode_dev = 3'b100;
      4'h7:    decode_dev = 3'b101;
      4'h8:    decode_dev = 3'b110;
      4'h9:    decode_dev = 3'b111;
      default: decode_dev = 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] dev_onehot(input logic [1:0] idx);
    case (idx)
      2'd0:    dev_onehot = 4'b0001;
      2'd1:    dev_onehot = 4'b0010;
      2'd2:    dev_onehot = 4'b0100;
      2'd3:    dev_onehot = 4'b1000;
      default: dev_onehot = 4'b0000;
    endcase
  endfunction

  state_t      state_r, state_next_s;
  logic [1:0]  dev_r;
  logic        wr_dir_r;
  logic [7:0]  count_r;

  logic [2:0]  dec_s;
  logic        mapped_s, req_s, illegal_s, sel_ready_s, timeout_s;
  logic [15:0] sel_rdata_s;
  logic        start_s, stall_s, err_set_s, rdata_ok_s, rdata_err_s;
  logic [1:0]  next_dev_s;
  logic        next_wr_s;
  logic        addr_unused_s;

  assign dec_s         = decode_dev(addr_low[7:4]);
  assign mapped_s      = dec_s[2];
  assign req_s         = io_read ^ io_write;
  assign illegal_s     = io_read & io_write;
  assign sel_ready_s   = dev_ready[dev_r];
  assign timeout_s     = (count_r == TIMEOUT_C);
  assign addr_unused_s = ^addr_low[3:0];
  assign next_dev_s    = start_s ? dec_s[1:0] : dev_r;
  assign next_wr_s     = start_s ? io_write : wr_dir_r;
  assign stall         = stall_s & ~reset;

  // Read-data slice of the device currently being accessed.
  always_comb begin
    sel_rdata_s = dev_rdata[15:0];
    case (dev_r)
      2'd0:    sel_rdata_s = dev_rdata[15:0];
      2'd1:    sel_rdata_s = dev_rdata[31:16];
      2'd2:    sel_rdata_s = dev_rdata[47:32];
      2'd3:    sel_rdata_s = dev_rdata[63:48];
      default: sel_rdata_s = dev_rdata[15:0];
    endcase
  end

  // Next-state and per-cycle control decisions.
  always_comb begin
    state_next_s = state_r;
    stall_s      = 1'b0;
    start_s      = 1'b0;
    err_set_s    = 1'b0;
    rdata_ok_s   = 1'b0;
    rdata_err_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (illegal_s) begin
          err_set_s = 1'b1;
        end else if (req_s) begin
          if (mapped_s) begin
            stall_s      = 1'b1;
            start_s      = 1'b1;
            state_next_s = REQ;
          end else begin
            // Unmapped access completes at once as a no-op.
            err_set_s   = 1'b1;
            rdata_err_s = io_read;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      REQ: begin
        stall_s = 1'b1;
        if (sel_ready_s) begin
          rdata_ok_s   = ~wr_dir_r;
          state_next_s = DONE;
        end else if (timeout_s) begin
          rdata_err_s  = ~wr_dir_r;
          err_set_s    = 1'b1;
          state_next_s = DONE;
        end else begin
          state_next_s = REQ;
        end
      end
      // Requests seen here still belong to the completing instruction.
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, latched access context and registered outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= IDLE;
      dev_r    <= 2'd0;
      wr_dir_r <= 1'b0;
      count_r  <= 8'd0;
      io_cs    <= 4'b0000;
      io_rd    <= 1'b0;
      io_wr    <= 1'b0;
      io_wdata <= 16'h0000;
      io_rdata <= 16'h0000;
      io_err   <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      dev_r    <= next_dev_s;
      wr_dir_r <= next_wr_s;
      if (start_s) begin
        count_r <= 8'd1;
      end else if (state_next_s == REQ) begin
        count_r <= count_r + 8'd1;
      end else begin
        count_r <= 8'd0;
      end
      if (state_next_s == REQ) begin
        io_cs <= dev_onehot(next_dev_s);
        io_rd <= ~next_wr_s;
        io_wr <= next_wr_s;
      end else begin
        io_cs <= 4'b0000;
        io_rd <= 1'b0;
        io_wr <= 1'b0;
      end
      if (start_s && io_write) begin
        io_wdata <= wdata;
      end
      if (rdata_ok_s) begin
        io_rdata <= sel_rdata_s;
      end else if (rdata_err_s) begin
        io_rdata <= ERR_DATA;
      end
      // A new error outranks a simultaneous clear.
      if (err_set_s) begin
        io_err <= 1'b1;
      end else if (err_clr) begin
        io_err <= 1'b0;
      end
    end
  end

endmodule
